// File: rtl/spi_flash_pkg.sv
// Shared opcodes, phase lengths and the controller state encoding for the
// SPI flash stream reader.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam int         DUMMY_CLKS   = 8;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    PAUSE,
    FINISH
  } state_t;

  function automatic logic [7:0] opcode_for(input logic fast);
    return fast ? OP_FAST_READ : OP_READ;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Serial clock divider: toggles sck every CLK_DIV cycles while run is high and
// flags the cycle in which each half-period boundary, rise or fall occurs.
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  input  logic rise_en,
  output logic sck,
  output logic half,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             sck_reg;

  // With rise_en low a boundary still reports half but sck stays parked low.
  assign half = run && (cnt_reg == CNT_MAX);
  assign rise = half && !sck_reg && rise_en;
  assign fall = half && sck_reg;
  assign sck  = sck_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      sck_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg <= '0;
      sck_reg <= 1'b0;
    end else if (run) begin
      cnt_reg <= half ? '0 : cnt_reg + CNT_W'(1);
      if (rise) begin
        sck_reg <= 1'b1;
      end else if (fall) begin
        sck_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_flash_stream_reader.sv
// SPI mode-0 flash reader: issues READ/FAST_READ, then streams DATA_W-bit words
// out through a valid/ready register, stalling the serial clock on backpressure.
module spi_flash_stream_reader
  import spi_flash_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 20
) (
  input  logic              clock,
  input  logic              flash_rstn,
  input  logic              start,
  input  logic [23:0]       start_addr,
  input  logic [LEN_W-1:0]  word_len,
  input  logic              fast_mode,
  input  logic              abort,
  output logic              flash_clk,
  output logic              flash_cs_n,
  output logic              flash_mosi,
  input  logic              flash_miso,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy,
  output logic              done
);

  state_t             state_reg, state_next;
  logic               fast_reg, fast_next;
  logic [31:0]        tx_sr_reg, tx_sr_next;
  logic [5:0]         bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]  rx_sr_reg, rx_sr_next;
  logic               pending_reg, pending_next;
  logic [LEN_W-1:0]   word_cnt_reg, word_cnt_next;
  logic               cs_n_reg, cs_n_next;
  logic               mosi_reg, mosi_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               valid_reg, valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic               sck_clr, sck_run, sck_rise_en;
  logic               sck_half, sck_rise, sck_fall;
  logic               out_free, load;
  logic [DATA_W-1:0]  load_word, rx_shift;
  logic [31:0]        cmd_word;

  assign cmd_word = {opcode_for(fast_mode), start_addr};
  assign rx_shift = {rx_sr_reg[DATA_W-2:0], flash_miso};
  assign out_free = !valid_reg || ready_i;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk     (clock),
    .rst_n   (flash_rstn),
    .clr     (sck_clr),
    .run     (sck_run),
    .rise_en (sck_rise_en),
    .sck     (flash_clk),
    .half    (sck_half),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  always_comb begin
    state_next    = state_reg;
    fast_next     = fast_reg;
    tx_sr_next    = tx_sr_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_sr_next    = rx_sr_reg;
    pending_next  = pending_reg;
    word_cnt_next = word_cnt_reg;
    cs_n_next     = cs_n_reg;
    mosi_next     = mosi_reg;
    data_next     = data_reg;
    valid_next    = valid_reg;
    done_next     = 1'b0;
    sck_clr       = 1'b0;
    sck_run       = 1'b0;
    sck_rise_en   = 1'b1;
    load          = 1'b0;
    load_word     = rx_sr_reg;

    if (valid_reg && ready_i) begin
      valid_next = 1'b0;
    end
    // Only the final word can sit in the output register once FINISH is reached.
    if (state_reg == FINISH && valid_reg && ready_i) begin
      done_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        sck_clr   = 1'b1;
        cs_n_next = 1'b1;
        mosi_next = 1'b1;
        if (start) begin
          fast_next     = fast_mode;
          tx_sr_next    = cmd_word;
          word_cnt_next = word_len;
          bit_cnt_next  = '0;
          pending_next  = 1'b0;
          if (word_len == '0) begin
            state_next = FINISH;
            done_next  = 1'b1;
          end else begin
            state_next = CMD;
            cs_n_next  = 1'b0;
            mosi_next  = cmd_word[31];
          end
        end
      end

      CMD: begin
        sck_run = 1'b1;
        if (sck_fall) begin
          mosi_next  = tx_sr_reg[30];
          tx_sr_next = tx_sr_reg << 1;
          if (bit_cnt_reg == 6'(CMD_BITS - 1)) begin
            bit_cnt_next = '0;
            state_next   = ADDR;
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end

      ADDR: begin
        sck_run = 1'b1;
        if (sck_fall) begin
          if (bit_cnt_reg == 6'(ADDR_BITS - 1)) begin
            mosi_next    = 1'b1;
            bit_cnt_next = '0;
            state_next   = fast_reg ? DUMMY : DATA;
          end else begin
            mosi_next    = tx_sr_reg[30];
            tx_sr_next   = tx_sr_reg << 1;
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end

      DUMMY: begin
        sck_run = 1'b1;
        if (sck_fall) begin
          if (bit_cnt_reg == 6'(DUMMY_CLKS - 1)) begin
            bit_cnt_next = '0;
            state_next   = DATA;
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end
      end

      DATA: begin
        sck_run = 1'b1;
        if (sck_rise) begin
          rx_sr_next = rx_shift;
          if (bit_cnt_reg == 6'(DATA_W - 1)) begin
            bit_cnt_next = '0;
            if (out_free) begin
              load      = 1'b1;
              load_word = rx_shift;
            end else begin
              pending_next = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
          end
        end else if (pending_reg) begin
          // Park after the falling edge so the flash already presents the next bit.
          if (out_free) begin
            load = 1'b1;
          end else if (sck_fall) begin
            state_next = PAUSE;
          end
        end
      end

      PAUSE: begin
        if (out_free) begin
          load = 1'b1;
        end
      end

      FINISH: begin
        sck_run     = !cs_n_reg;
        sck_rise_en = 1'b0;
        if (sck_half && !flash_clk) begin
          cs_n_next = 1'b1;
        end
        if (cs_n_reg && !valid_reg) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (load) begin
      data_next     = load_word;
      valid_next    = 1'b1;
      pending_next  = 1'b0;
      word_cnt_next = word_cnt_reg - LEN_W'(1);
      if (word_cnt_reg == LEN_W'(1)) begin
        state_next = FINISH;
      end else if (state_reg == PAUSE) begin
        state_next = DATA;
      end
    end

    if (abort) begin
      state_next   = IDLE;
      cs_n_next    = 1'b1;
      mosi_next    = 1'b1;
      valid_next   = 1'b0;
      done_next    = 1'b0;
      pending_next = 1'b0;
      bit_cnt_next = '0;
      sck_clr      = 1'b1;
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge flash_rstn) begin
    if (!flash_rstn) begin
      state_reg    <= IDLE;
      fast_reg     <= 1'b0;
      tx_sr_reg    <= '0;
      bit_cnt_reg  <= '0;
      rx_sr_reg    <= '0;
      pending_reg  <= 1'b0;
      word_cnt_reg <= '0;
      cs_n_reg     <= 1'b1;
      mosi_reg     <= 1'b1;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fast_reg     <= fast_next;
      tx_sr_reg    <= tx_sr_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_sr_reg    <= rx_sr_next;
      pending_reg  <= pending_next;
      word_cnt_reg <= word_cnt_next;
      cs_n_reg     <= cs_n_next;
      mosi_reg     <= mosi_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign flash_cs_n = cs_n_reg;
  assign flash_mosi = mosi_reg;
  assign data_o     = data_reg;
  assign valid_o    = valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Bench for spi_flash_stream_reader: behavioural serial flash, word scoreboard
// and directed plus randomized read transactions.
module tb_spi_flash_stream_reader;

  localparam int DW    = 16;
  localparam int NB    = DW / 8;
  localparam int LW    = 20;
  localparam int CDIV  = 2;

  logic          clock = 1'b0;
  logic          flash_rstn = 1'b0;
  logic          start = 1'b0;
  logic [23:0]   start_addr = '0;
  logic [LW-1:0] word_len = '0;
  logic          fast_mode = 1'b0;
  logic          abort = 1'b0;
  logic          flash_clk, flash_cs_n, flash_mosi;
  logic          flash_miso = 1'b0;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          busy, done;

  spi_flash_stream_reader #(
    .DATA_W  (DW),
    .CLK_DIV (CDIV),
    .LEN_W   (LW)
  ) dut (
    .clock      (clock),
    .flash_rstn (flash_rstn),
    .start      (start),
    .start_addr (start_addr),
    .word_len   (word_len),
    .fast_mode  (fast_mode),
    .abort      (abort),
    .flash_clk  (flash_clk),
    .flash_cs_n (flash_cs_n),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // flash model state
  logic [31:0] fr_cmd;
  int          fr_rises, fr_dbit, cs_falls, dummy_bad;
  logic        prev_sck = 1'b0, prev_cs = 1'b1;
  // scoreboard / monitor state
  logic [DW-1:0] exp_q[$];
  int            done_cnt, valid_cnt, rmode, hold_left, cs_high_hold, sck_tail_high;
  bit            seen_valid;
  logic          prev_valid = 1'b0, prev_taken = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h060000: return 8'hA5;
      24'h060001: return 8'hA5;
      24'h060002: return 8'h12;
      24'h060003: return 8'h34;
      default:    return (a[7:0] * 8'd29) ^ a[15:8] ^ (a[23:16] + 8'h5A);
    endcase
  endfunction

  task automatic cycle();
    logic [7:0]  b;
    logic [23:0] ba;
    @(negedge clock);
    // flash side: sample mosi on rises, present the next data bit on falls
    if (!flash_cs_n && prev_cs) begin
      fr_rises = 0; fr_dbit = 0; fr_cmd = '0; cs_falls++;
    end
    if (!flash_cs_n && flash_clk && !prev_sck) begin
      if (fr_rises < 32) fr_cmd = {fr_cmd[30:0], flash_mosi};
      else if (fr_cmd[31:24] == 8'h0B && fr_rises < 40 && !flash_mosi) dummy_bad++;
      fr_rises++;
    end
    if (!flash_cs_n && !flash_clk && prev_sck && fr_rises >= 32 &&
        fr_rises >= ((fr_cmd[31:24] == 8'h0B) ? 40 : 32)) begin
      ba = fr_cmd[23:0] + 24'(fr_dbit / 8);
      b  = mem_byte(ba);
      flash_miso = b[7 - (fr_dbit % 8)];
      fr_dbit++;
    end
    prev_sck = flash_clk;
    prev_cs  = flash_cs_n;
    // downstream side
    if (valid_o) valid_cnt++;
    if (done) done_cnt++;
    if (prev_valid && !prev_taken && valid_o) check("data_hold", data_o, prev_data);
    case (rmode)
      1: ready_i = 1'($urandom_range(0, 1));
      2: begin
        if (!seen_valid && valid_o) begin seen_valid = 1; hold_left = 100; end
        if (hold_left > 0) begin
          ready_i = 1'b0;
          if (flash_cs_n) cs_high_hold++;
          if (hold_left <= 20 && flash_clk) sck_tail_high++;
          hold_left--;
        end else ready_i = 1'b1;
      end
      default: ready_i = 1'b1;
    endcase
    if (valid_o && ready_i) begin
      check("word_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("data", data_o, exp_q.pop_front());
    end
    prev_valid = valid_o;
    prev_taken = valid_o && ready_i;
    prev_data  = data_o;
  endtask

  task automatic start_txn(input logic [23:0] a, input int len, input bit f, input int mode);
    logic [DW-1:0] w;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      w = '0;
      for (int k = 0; k < NB; k++) w = (w << 8) | DW'(mem_byte(a + 24'(i * NB + k)));
      exp_q.push_back(w);
    end
    done_cnt = 0; valid_cnt = 0; cs_falls = 0; dummy_bad = 0;
    rmode = mode; seen_valid = 0; hold_left = 0; cs_high_hold = 0; sck_tail_high = 0;
    start = 1'b1; start_addr = a; word_len = LW'(len); fast_mode = f;
    cycle();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (len == 0) check("done_len0", done, 1);
  endtask

  task automatic finish_txn(input logic [23:0] a, input int len, input bit f);
    int n = 0;
    while (busy && n < 20000) begin cycle(); n++; end
    check("txn_timeout", 32'(n < 20000), 1);
    repeat (4) cycle();
    check("words_left", exp_q.size(), 0);
    check("done_count", done_cnt, 1);
    check("cs_falls", cs_falls, (len > 0) ? 1 : 0);
    if (len > 0) begin
      check("opcode", fr_cmd[31:24], f ? 8'h0B : 8'h03);
      check("addr", fr_cmd[23:0], a);
      check("sck_rises", fr_rises, 32 + (f ? 8 : 0) + DW * len);
      check("dummy_mosi", dummy_bad, 0);
    end
    $display("txn addr=%06h len=%0d fast=%0d mode=%0d cycles=%0d rises=%0d done=%0d",
             a, len, f, rmode, n, fr_rises, done_cnt);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (fr_rises < target && n < 5000) begin cycle(); n++; end
    check("reach_rise", 32'(n < 5000), 1);
  endtask

  initial begin
    logic [23:0] a;
    int          len;
    bit          f;
    repeat (3) cycle();
    check("rst_cs_n", flash_cs_n, 1);
    check("rst_sck", flash_clk, 0);
    check("rst_mosi", flash_mosi, 1);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_o, 0);
    flash_rstn = 1'b1;
    repeat (2) cycle();

    // reference reads, plain and fast
    start_txn(24'h060000, 2, 0, 0);
    finish_txn(24'h060000, 2, 0);
    start_txn(24'h060000, 2, 1, 0);
    finish_txn(24'h060000, 2, 1);

    // backpressure: serial clock must park low with cs_n still asserted
    start_txn(24'h060000, 2, 0, 2);
    finish_txn(24'h060000, 2, 0);
    check("pause_cs_high", cs_high_hold, 0);
    check("pause_sck_high", sck_tail_high, 0);

    // empty request
    start_txn(24'h123456, 0, 0, 0);
    finish_txn(24'h123456, 0, 0);

    // abort part way through the address phase
    start_txn(24'h0ABCDE, 4, 0, 0);
    wait_rises(18);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_cs_n", flash_cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_sck", flash_clk, 0);
    valid_cnt = 0; done_cnt = 0;
    repeat (30) cycle();
    check("abort_valid", valid_cnt, 0);
    check("abort_done", done_cnt, 0);
    start_txn(24'h0ABCDE, 3, 1, 0);
    finish_txn(24'h0ABCDE, 3, 1);

    // asynchronous reset in the middle of the data phase
    start_txn(24'h200000, 3, 0, 0);
    wait_rises(40);
    #2 flash_rstn = 1'b0;
    #1;
    check("arst_cs_n", flash_cs_n, 1);
    check("arst_sck", flash_clk, 0);
    check("arst_mosi", flash_mosi, 1);
    check("arst_data", data_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (2) cycle();
    flash_rstn = 1'b1;
    repeat (2) cycle();
    start_txn(24'h200000, 2, 0, 1);
    finish_txn(24'h200000, 2, 0);

    // randomized reads, including ones that run across the top of the array
    for (int i = 0; i < 14; i++) begin
      a   = 24'($urandom);
      if (i % 4 == 3) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
      len = $urandom_range(0, 4);
      f   = 1'($urandom_range(0, 1));
      start_txn(a, len, f, $urandom_range(0, 1));
      finish_txn(a, len, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
